// File: rtl/pwm_csr.sv
// -----------------------------------------------------------------------------
// PwmCsr : control/status register file for the PWM generator.
//
// A bus master programs the PWM core through a chipselect/read/write slave
// port. The enable, period, duty-cycle and divisor registers drive the core
// directly. A status word reflects the core's running flag back to software.
//
// Register map (word address):
//   0 CTRL    RW  bit0 = enable
//   1 STATUS  RO  bit0 = pwm_running, sampled live at the read edge
//   2 PERIOD  RW  bits15:0
//   3 DUTY    RW  bits15:0
//   4 DIVISOR RW  bits15:0
//   5-7       read as zero, writes ignored
//
// Ports:
//   clk_i          clock; all state changes on the rising edge
//   reset_i        synchronous active-high reset; wins over any bus access
//   chipselect_i   slave select; read/write strobes are ignored when low
//   write_i        write strobe
//   read_i         read strobe
//   address_i      register word address
//   writedata_i    write data
//   readdata_o     registered read data, valid the cycle after a read
//   enable_o       PWM enable
//   period_o       PWM period in divided-clock ticks
//   duty_cycle_o   PWM high time in divided-clock ticks
//   divisor_o      clock prescaler for the PWM core
//   pwm_running_i  running flag from the PWM core
// -----------------------------------------------------------------------------
module pwm_csr #(
   parameter logic [15:0] PERIOD_RST  = 16'h0000,
   parameter logic [15:0] DUTY_RST    = 16'h0000,
   parameter logic [15:0] DIVISOR_RST = 16'h0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        chipselect_i,
   input  logic        write_i,
   input  logic        read_i,
   input  logic [2:0]  address_i,
   input  logic [31:0] writedata_i,
   output logic [31:0] readdata_o,
   output logic        enable_o,
   output logic [15:0] period_o,
   output logic [15:0] duty_cycle_o,
   output logic [15:0] divisor_o,
   input  logic        pwm_running_i
);

   typedef enum logic [2:0] {
      ADDR_CTRL    = 3'd0,
      ADDR_STATUS  = 3'd1,
      ADDR_PERIOD  = 3'd2,
      ADDR_DUTY    = 3'd3,
      ADDR_DIVISOR = 3'd4
   } regAddr_e;

   logic        enable_q,   enable_d;
   logic [15:0] period_q,   period_d;
   logic [15:0] duty_q,     duty_d;
   logic [15:0] divisor_q,  divisor_d;
   logic [31:0] readdata_q, readdata_d;

   logic        wrEn;
   logic        rdEn;
   logic [31:0] readMux;

   assign wrEn = chipselect_i & write_i;
   assign rdEn = chipselect_i & read_i;

   // Read mux works from the current register values, so a read and a write
   // to the same address in one cycle returns the value from before the write.
   always_comb begin
      readMux = 32'h0;
      case (address_i)
         ADDR_CTRL:    readMux = {31'h0, enable_q};
         ADDR_STATUS:  readMux = {31'h0, pwm_running_i};
         ADDR_PERIOD:  readMux = {16'h0, period_q};
         ADDR_DUTY:    readMux = {16'h0, duty_q};
         ADDR_DIVISOR: readMux = {16'h0, divisor_q};
         default:      readMux = 32'h0;
      endcase
   end

   // Next-state logic: every register holds unless the bus addresses it.
   // Values are passed through without range checks (duty > period and a
   // zero divisor are left for the core to deal with).
   always_comb begin
      enable_d   = enable_q;
      period_d   = period_q;
      duty_d     = duty_q;
      divisor_d  = divisor_q;
      readdata_d = readdata_q;

      if (wrEn) begin
         case (address_i)
            ADDR_CTRL:    enable_d  = writedata_i[0];
            ADDR_PERIOD:  period_d  = writedata_i[15:0];
            ADDR_DUTY:    duty_d    = writedata_i[15:0];
            ADDR_DIVISOR: divisor_d = writedata_i[15:0];
            default:      ;
         endcase
      end

      if (rdEn) begin
         readdata_d = readMux;
      end
   end

   // State registers with synchronous reset taking priority over the bus.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         enable_q   <= 1'b0;
         period_q   <= PERIOD_RST;
         duty_q     <= DUTY_RST;
         divisor_q  <= DIVISOR_RST;
         readdata_q <= 32'h0;
      end else begin
         enable_q   <= enable_d;
         period_q   <= period_d;
         duty_q     <= duty_d;
         divisor_q  <= divisor_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata_o   = readdata_q;
   assign enable_o     = enable_q;
   assign period_o     = period_q;
   assign duty_cycle_o = duty_q;
   assign divisor_o    = divisor_q;

endmodule

// File: tb/tb_pwm_csr.sv
// -----------------------------------------------------------------------------
// TbPwmCsr : self-checking bench for pwm_csr.
//
// Each stimulus record carries the bus cycle to drive and the register state
// expected after the following rising edge. Expectations are queued when a
// cycle is driven and popped once the DUT has clocked it.
// -----------------------------------------------------------------------------
module tb_pwm_csr;

   logic        clk;
   logic        reset;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        enable;
   logic [15:0] period;
   logic [15:0] dutyCycle;
   logic [15:0] divisor;
   logic        pwmRunning;

   typedef struct {
      logic        rst;
      logic        cs;
      logic        wr;
      logic        rd;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic        run;
      logic        expEnable;
      logic [15:0] expPeriod;
      logic [15:0] expDuty;
      logic [15:0] expDivisor;
      logic [31:0] expRead;
   } vector_t;

   typedef struct {
      logic        enable;
      logic [15:0] period;
      logic [15:0] duty;
      logic [15:0] divisor;
      logic [31:0] readdata;
   } expect_t;

   expect_t expQueue[$];
   vector_t vectors[$];

   int checks = 0;
   int errors = 0;

   pwm_csr dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .chipselect_i  (chipselect),
      .write_i       (write),
      .read_i        (read),
      .address_i     (address),
      .writedata_i   (writedata),
      .readdata_o    (readdata),
      .enable_o      (enable),
      .period_o      (period),
      .duty_cycle_o  (dutyCycle),
      .divisor_o     (divisor),
      .pwm_running_i (pwmRunning)
   );

   // Free-running 10 time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Drive one bus cycle on the falling edge and queue its expectation.
   task automatic applyStimulus(input vector_t v);
      expect_t e;
      @(negedge clk);
      reset      = v.rst;
      chipselect = v.cs;
      write      = v.wr;
      read       = v.rd;
      address    = v.addr;
      writedata  = v.wdata;
      pwmRunning = v.run;
      e.enable   = v.expEnable;
      e.period   = v.expPeriod;
      e.duty     = v.expDuty;
      e.divisor  = v.expDivisor;
      e.readdata = v.expRead;
      expQueue.push_back(e);
   endtask

   // Compare the DUT just after the rising edge against the oldest entry.
   task automatic checkOutput(input string tag);
      expect_t e;
      @(posedge clk);
      #1;
      if (expQueue.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, got readdata 0x%08h expected an entry",
                  tag, readdata);
      end else begin
         e = expQueue.pop_front();
         checkField({tag, ".enable"},   {31'h0, enable},    {31'h0, e.enable});
         checkField({tag, ".period"},   {16'h0, period},    {16'h0, e.period});
         checkField({tag, ".duty"},     {16'h0, dutyCycle}, {16'h0, e.duty});
         checkField({tag, ".divisor"},  {16'h0, divisor},   {16'h0, e.divisor});
         checkField({tag, ".readdata"}, readdata,           e.readdata);
      end
   endtask

   function automatic vector_t mk(input logic rst, input logic cs,
                                  input logic wr, input logic rd,
                                  input logic [2:0] addr, input logic [31:0] wdata,
                                  input logic run, input logic en,
                                  input logic [15:0] per, input logic [15:0] duty,
                                  input logic [15:0] div, input logic [31:0] rdat);
      vector_t v;
      v.rst = rst; v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr;
      v.wdata = wdata; v.run = run; v.expEnable = en; v.expPeriod = per;
      v.expDuty = duty; v.expDivisor = div; v.expRead = rdat;
      return v;
   endfunction

   initial begin
      reset      = 1'b1;
      chipselect = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      address    = 3'd0;
      writedata  = 32'h0;
      pwmRunning = 1'b0;

      //            rst cs wr rd addr wdata          run en per      duty     div      readdata
      // Reset held for two cycles
      vectors.push_back(mk(1, 0, 0, 0, 3'd0, 32'h0,        0, 0, 16'h0,   16'h0,   16'h0,   32'h0));
      vectors.push_back(mk(1, 1, 1, 1, 3'd2, 32'h1234,     0, 0, 16'h0,   16'h0,   16'h0,   32'h0));
      // Configuration writes
      vectors.push_back(mk(0, 1, 1, 0, 3'd0, 32'h1,        0, 1, 16'h0,   16'h0,   16'h0,   32'h0));
      vectors.push_back(mk(0, 1, 1, 0, 3'd2, 32'h100,      0, 1, 16'h100, 16'h0,   16'h0,   32'h0));
      vectors.push_back(mk(0, 1, 1, 0, 3'd3, 32'h80,       0, 1, 16'h100, 16'h80,  16'h0,   32'h0));
      vectors.push_back(mk(0, 1, 1, 0, 3'd4, 32'h10,       0, 1, 16'h100, 16'h80,  16'h10,  32'h0));
      // Read back
      vectors.push_back(mk(0, 1, 0, 1, 3'd0, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 1, 0, 1, 3'd2, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h100));
      vectors.push_back(mk(0, 1, 0, 1, 3'd3, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h80));
      vectors.push_back(mk(0, 1, 0, 1, 3'd4, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h10));
      // Upper bits of PERIOD dropped on write, read back as zero
      vectors.push_back(mk(0, 1, 1, 0, 3'd2, 32'hFFFF0100, 0, 1, 16'h100, 16'h80,  16'h10,  32'h10));
      vectors.push_back(mk(0, 1, 0, 1, 3'd2, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h100));
      // STATUS follows pwm_running, writes to it do nothing
      vectors.push_back(mk(0, 1, 0, 1, 3'd1, 32'h0,        1, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 1, 0, 1, 3'd1, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h0));
      vectors.push_back(mk(0, 1, 1, 0, 3'd1, 32'hFFFFFFFF, 0, 1, 16'h100, 16'h80,  16'h10,  32'h0));
      vectors.push_back(mk(0, 1, 0, 1, 3'd0, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      // No chipselect: nothing changes, readdata holds
      vectors.push_back(mk(0, 0, 1, 0, 3'd0, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 0, 1, 1, 3'd2, 32'h55,       1, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      // Unmapped addresses
      vectors.push_back(mk(0, 1, 1, 0, 3'd5, 32'hFFFFFFFF, 0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 1, 1, 0, 3'd6, 32'hFFFFFFFF, 0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 1, 1, 0, 3'd7, 32'hFFFFFFFF, 0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      vectors.push_back(mk(0, 1, 0, 1, 3'd6, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h0));
      // CTRL uses bit0 only
      vectors.push_back(mk(0, 1, 1, 0, 3'd0, 32'hFFFFFFFE, 0, 0, 16'h100, 16'h80,  16'h10,  32'h0));
      vectors.push_back(mk(0, 1, 1, 0, 3'd0, 32'h3,        0, 1, 16'h100, 16'h80,  16'h10,  32'h0));
      vectors.push_back(mk(0, 1, 0, 1, 3'd0, 32'h0,        0, 1, 16'h100, 16'h80,  16'h10,  32'h1));
      // duty > period and divisor = 0 accepted unchanged
      vectors.push_back(mk(0, 1, 1, 0, 3'd3, 32'h0000FFFF, 0, 1, 16'h100, 16'hFFFF, 16'h10, 32'h1));
      vectors.push_back(mk(0, 1, 1, 0, 3'd4, 32'h0,        0, 1, 16'h100, 16'hFFFF, 16'h0,  32'h1));
      vectors.push_back(mk(0, 1, 0, 1, 3'd3, 32'h0,        0, 1, 16'h100, 16'hFFFF, 16'h0,  32'hFFFF));
      vectors.push_back(mk(0, 1, 0, 1, 3'd4, 32'h0,        0, 1, 16'h100, 16'hFFFF, 16'h0,  32'h0));
      vectors.push_back(mk(0, 1, 0, 1, 3'd3, 32'h0,        0, 1, 16'h100, 16'hFFFF, 16'h0,  32'hFFFF));
      vectors.push_back(mk(0, 1, 0, 1, 3'd7, 32'h0,        0, 1, 16'h100, 16'hFFFF, 16'h0,  32'h0));

      for (int i = 0; i < vectors.size(); i++) begin
         applyStimulus(vectors[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // Read and write the same address in one cycle: old value returned,
      // new value stored, then visible on the next read.
      applyStimulus(mk(0, 1, 1, 1, 3'd2, 32'h1234, 0, 1, 16'h1234, 16'hFFFF, 16'h0, 32'h100));
      checkOutput("rdwrSame");
      applyStimulus(mk(0, 1, 0, 1, 3'd2, 32'h0,    0, 1, 16'h1234, 16'hFFFF, 16'h0, 32'h1234));
      checkOutput("rdwrAfter");

      // Write-only cycle leaves readdata holding.
      applyStimulus(mk(0, 1, 1, 0, 3'd4, 32'h7,    0, 1, 16'h1234, 16'hFFFF, 16'h7, 32'h1234));
      checkOutput("writeHold");

      // Reset mid-operation with a concurrent write and read: reset wins.
      applyStimulus(mk(1, 1, 1, 1, 3'd0, 32'h1,    1, 0, 16'h0,    16'h0,    16'h0, 32'h0));
      checkOutput("resetMid");
      applyStimulus(mk(0, 0, 0, 0, 3'd0, 32'h0,    0, 0, 16'h0,    16'h0,    16'h0, 32'h0));
      checkOutput("postReset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
